// File: rtl/iteration_memory_reader_pkg.sv
// Shared constants for the Mandelbrot frame buffer path: MCB command encodings,
// address width, default frame geometry and the reader FSM state type.
package iteration_memory_reader_pkg;

    localparam int ADDR_W = 30;

    localparam logic [2:0] MCB_WRITE = 3'b000;
    localparam logic [2:0] MCB_READ  = 3'b001;

    localparam int FRAME_WIDTH  = 640;
    localparam int FRAME_HEIGHT = 480;
    localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;

    typedef enum logic [2:0] {
        WAIT_CALIB,
        IDLE,
        ISSUE,
        DRAIN,
        FLUSH
    } rd_state_e;

endpackage

// File: rtl/iteration_memory_reader_fifo.sv
// Generic synchronous FIFO with show-ahead read data and a synchronous flush.
// Zero-cycle read of the head word; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     free_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign free_count = (AW+1)'(DEPTH) - count;
    assign pop_data   = mem[rd_ptr];
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/iteration_memory_reader.sv
// Streams the iteration frame back from DDR over MCB port 1 in fixed bursts into a local FIFO.
// One word per pixel_req, valid the cycle after; bursts only issue when the FIFO can absorb them.
module iteration_memory_reader
    import iteration_memory_reader_pkg::*;
#(
    parameter int                SET_SIZE    = 16,
    parameter int                FRAME_WORDS = FRAME_PIXELS,
    parameter logic [ADDR_W-1:0] FRAME_BASE  = '0,
    parameter int                FIFO_DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_calib_done,
    input  logic              p1_cmd_full,
    input  logic              p1_rd_empty,
    input  logic [31:0]       p1_rd_data,
    output logic              p1_cmd_en,
    output logic [2:0]        p1_cmd_instr,
    output logic [5:0]        p1_cmd_bl,
    output logic [ADDR_W-1:0] p1_cmd_byte_addr,
    output logic              p1_rd_en,
    input  logic              frame_start,
    input  logic              pixel_req,
    output logic [31:0]       pixel_data,
    output logic              pixel_valid,
    output logic              underflow
);

    localparam int FAW = $clog2(FIFO_DEPTH);

    rd_state_e         state;
    logic              calib_meta;
    logic              calib_sync;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       fetched;
    logic [31:0]       remaining;
    logic [5:0]        outstanding;
    logic [5:0]        out_dec;
    logic [5:0]        len;
    logic              fs;
    logic              can_issue;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [FAW:0]      fifo_free;
    logic [31:0]       fifo_dout;

    assign p1_cmd_instr = MCB_READ;

    // frame_start only means something once the memory is usable.
    assign fs        = frame_start && (state != WAIT_CALIB);
    assign p1_rd_en  = ((state == DRAIN) || (state == FLUSH)) && (outstanding != '0) && !p1_rd_empty;
    assign out_dec   = outstanding - {5'd0, p1_rd_en};
    assign fifo_push = p1_rd_en && (state == DRAIN) && !fs && !fifo_full;
    assign fifo_pop  = pixel_req && !fifo_empty && !fs;
    assign remaining = 32'(FRAME_WORDS) - fetched;
    assign len       = (remaining < 32'(SET_SIZE)) ? remaining[5:0] : 6'(SET_SIZE);
    assign can_issue = (fetched < 32'(FRAME_WORDS)) && (fifo_free >= (FAW+1)'(SET_SIZE)) && !p1_cmd_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            calib_meta <= 1'b0;
            calib_sync <= 1'b0;
        end else begin
            calib_meta <= mem_calib_done;
            calib_sync <= calib_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= WAIT_CALIB;
            ptr              <= FRAME_BASE;
            fetched          <= '0;
            outstanding      <= '0;
            p1_cmd_en        <= 1'b0;
            p1_cmd_bl        <= '0;
            p1_cmd_byte_addr <= '0;
        end else begin
            p1_cmd_en <= 1'b0;
            case (state)
                WAIT_CALIB: if (calib_sync) state <= IDLE;
                IDLE: begin
                    if (!fs && can_issue) begin
                        p1_cmd_en        <= 1'b1;
                        p1_cmd_bl        <= len - 6'd1;
                        p1_cmd_byte_addr <= ptr;
                        ptr              <= ptr + ADDR_W'({len, 2'b00});
                        fetched          <= fetched + 32'(len);
                        outstanding      <= len;
                        state            <= ISSUE;
                    end
                end
                // A command already handed to the MCB must still be drained, even across a restart.
                ISSUE: state <= fs ? FLUSH : DRAIN;
                DRAIN: begin
                    outstanding <= out_dec;
                    if (out_dec == '0) state <= IDLE;
                    else if (fs)       state <= FLUSH;
                end
                FLUSH: begin
                    outstanding <= out_dec;
                    if (out_dec == '0) state <= IDLE;
                end
                default: state <= WAIT_CALIB;
            endcase
            if (fs) begin
                ptr     <= FRAME_BASE;
                fetched <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            pixel_valid <= fifo_pop;
            if (fifo_pop) pixel_data <= fifo_dout;
            if (pixel_req && fifo_empty && !fs) underflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (fs),
        .push       (fifo_push),
        .push_data  (p1_rd_data),
        .pop        (fifo_pop),
        .pop_data   (fifo_dout),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .free_count (fifo_free)
    );

endmodule

// File: tb/tb_iteration_memory_reader.sv
// Directed bench: small 40-word frame, 16-word bursts, 32-deep FIFO, MCB model answering word index as data.
module tb_iteration_memory_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_calib_done = 1'b0;
    logic        p1_cmd_full = 1'b0;
    logic        p1_rd_empty = 1'b1;
    logic [31:0] p1_rd_data = '0;
    logic        p1_cmd_en;
    logic [2:0]  p1_cmd_instr;
    logic [5:0]  p1_cmd_bl;
    logic [29:0] p1_cmd_byte_addr;
    logic        p1_rd_en;
    logic        frame_start = 1'b0;
    logic        pixel_req = 1'b0;
    logic [31:0] pixel_data;
    logic        pixel_valid;
    logic        underflow;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mcb_q[$];
    logic [29:0] cmd_addr_q[$];
    logic [5:0]  cmd_bl_q[$];
    int          q_at_cmd[$];
    int          pops_at_cmd[$];
    int          pop_cnt = 0;

    iteration_memory_reader #(
        .SET_SIZE    (16),
        .FRAME_WORDS (40),
        .FRAME_BASE  (30'd0),
        .FIFO_DEPTH  (32)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mem_calib_done   (mem_calib_done),
        .p1_cmd_full      (p1_cmd_full),
        .p1_rd_empty      (p1_rd_empty),
        .p1_rd_data       (p1_rd_data),
        .p1_cmd_en        (p1_cmd_en),
        .p1_cmd_instr     (p1_cmd_instr),
        .p1_cmd_bl        (p1_cmd_bl),
        .p1_cmd_byte_addr (p1_cmd_byte_addr),
        .p1_rd_en         (p1_rd_en),
        .frame_start      (frame_start),
        .pixel_req        (pixel_req),
        .pixel_data       (pixel_data),
        .pixel_valid      (pixel_valid),
        .underflow        (underflow)
    );

    always #5 clk = ~clk;

    // MCB port model: sample the handshake at the edge, update its outputs just after it.
    always @(posedge clk) begin
        bit          do_pop;
        bit          do_cmd;
        logic [29:0] a;
        logic [5:0]  b;
        do_pop = p1_rd_en && !p1_rd_empty;
        do_cmd = p1_cmd_en;
        a = p1_cmd_byte_addr;
        b = p1_cmd_bl;
        #1;
        if (do_pop) begin
            void'(mcb_q.pop_front());
            pop_cnt++;
        end
        if (do_cmd) begin
            cmd_addr_q.push_back(a);
            cmd_bl_q.push_back(b);
            q_at_cmd.push_back(mcb_q.size());
            pops_at_cmd.push_back(pop_cnt);
            for (int i = 0; i <= int'(b); i++) mcb_q.push_back(32'(a >> 2) + 32'(i));
        end
        p1_rd_empty = (mcb_q.size() == 0);
        p1_rd_data  = p1_rd_empty ? 32'd0 : mcb_q[0];
    end

    task automatic wait_cmds(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (cmd_addr_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors += 8;
        if (p1_cmd_en !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_en got %0b want 0", p1_cmd_en); end
        if (p1_cmd_instr !== 3'b001) begin miscompares++; $display("FAIL reset_instr got %0b want 001", p1_cmd_instr); end
        if (p1_cmd_bl !== 6'd0) begin miscompares++; $display("FAIL reset_bl got %0d want 0", p1_cmd_bl); end
        if (p1_cmd_byte_addr !== 30'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", p1_cmd_byte_addr); end
        if (p1_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en got %0b want 0", p1_rd_en); end
        if (pixel_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pixel_valid got %0b want 0", pixel_valid); end
        if (pixel_data !== 32'd0) begin miscompares++; $display("FAIL reset_pixel_data got %0d want 0", pixel_data); end
        if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow got %0b want 0", underflow); end
        reset_n = 1'b1;
    endtask

    task automatic test_calib_gating();
        int lat;
        int seen;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (p1_cmd_en) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL calib_gate cmd_en cycles got %0d want 0", seen); end
        // Raised mid-cycle: edge 1 captures it, the command must show 3 cycles after that edge.
        mem_calib_done = 1'b1;
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (p1_cmd_en) begin
                lat = e;
                break;
            end
        end
        p1_cmd_full = 1'b1;
        vectors += 4;
        if (lat !== 1 + 3) begin miscompares++; $display("FAIL calib_latency got %0d edges want 4", lat); end
        if (p1_cmd_byte_addr !== 30'd0) begin miscompares++; $display("FAIL calib_addr got %0d want 0", p1_cmd_byte_addr); end
        if (p1_cmd_bl !== 6'd15) begin miscompares++; $display("FAIL calib_bl got %0d want 15", p1_cmd_bl); end
        if (p1_cmd_instr !== 3'b001) begin miscompares++; $display("FAIL calib_instr got %0b want 001", p1_cmd_instr); end
    endtask

    task automatic test_backpressure();
        bit ok;
        repeat (40) @(negedge clk);
        vectors++;
        if (cmd_addr_q.size() !== 1) begin miscompares++; $display("FAIL bp_cmd_full_hold commands got %0d want 1", cmd_addr_q.size()); end
        p1_cmd_full = 1'b0;
        wait_cmds(2, 10, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL bp_release_timeout commands got %0d want 2", cmd_addr_q.size()); end
        else begin
            vectors += 2;
            if (cmd_addr_q[1] !== 30'd64) begin miscompares++; $display("FAIL bp_cmd2_addr got %0d want 64", cmd_addr_q[1]); end
            if (cmd_bl_q[1] !== 6'd15) begin miscompares++; $display("FAIL bp_cmd2_bl got %0d want 15", cmd_bl_q[1]); end
        end
        repeat (40) @(negedge clk);
        vectors++;
        if (cmd_addr_q.size() !== 2) begin miscompares++; $display("FAIL bp_fifo_full_hold commands got %0d want 2", cmd_addr_q.size()); end
    endtask

    task automatic test_pixel_stream();
        bit ok;
        pixel_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) pixel_req = 1'b0;
            vectors += 3;
            if (pixel_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got %0b want 1", i, pixel_valid); end
            if (pixel_data !== 32'(i)) begin miscompares++; $display("FAIL stream_data[%0d] got %0d want %0d", i, pixel_data, i); end
            if (underflow !== 1'b0) begin miscompares++; $display("FAIL stream_underflow[%0d] got %0b want 0", i, underflow); end
        end
        wait_cmds(3, 20, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL frame_cmd3_timeout commands got %0d want 3", cmd_addr_q.size()); end
        else begin
            vectors += 2;
            if (cmd_addr_q[2] !== 30'd128) begin miscompares++; $display("FAIL frame_cmd3_addr got %0d want 128", cmd_addr_q[2]); end
            if (cmd_bl_q[2] !== 6'd7) begin miscompares++; $display("FAIL frame_cmd3_bl got %0d want 7", cmd_bl_q[2]); end
        end
    endtask

    task automatic test_back_to_back();
        // Reads overlap the tail burst, so the FIFO sees push and pop in the same cycles.
        pixel_req = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 23) pixel_req = 1'b0;
            vectors += 2;
            if (pixel_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d] got %0b want 1", i, pixel_valid); end
            if (pixel_data !== 32'(16 + i)) begin miscompares++; $display("FAIL b2b_data[%0d] got %0d want %0d", i, pixel_data, 16 + i); end
        end
        repeat (50) @(negedge clk);
        vectors += 2;
        if (cmd_addr_q.size() !== 3) begin miscompares++; $display("FAIL frame_done_idle commands got %0d want 3", cmd_addr_q.size()); end
        if (pixel_valid !== 1'b0) begin miscompares++; $display("FAIL frame_done_valid got %0b want 0", pixel_valid); end
    endtask

    task automatic test_underflow();
        pixel_req = 1'b1;
        @(negedge clk);
        pixel_req = 1'b0;
        vectors += 3;
        if (pixel_valid !== 1'b0) begin miscompares++; $display("FAIL underflow_valid got %0b want 0", pixel_valid); end
        if (underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_flag got %0b want 1", underflow); end
        if (pixel_data !== 32'd39) begin miscompares++; $display("FAIL underflow_hold_data got %0d want 39", pixel_data); end
    endtask

    task automatic test_frame_restart();
        bit ok;
        int base;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_cmds(4, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL restart_cmd4_timeout commands got %0d want 4", cmd_addr_q.size());
            return;
        end
        vectors++;
        if (cmd_addr_q[3] !== 30'd0) begin miscompares++; $display("FAIL restart_cmd4_addr got %0d want 0", cmd_addr_q[3]); end
        base = pops_at_cmd[3];
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (pop_cnt - base == 5) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL midburst_pop_timeout pops got %0d want 5", pop_cnt - base); end
        // Restart with a request pending and words already buffered: the restart must win.
        frame_start = 1'b1;
        pixel_req   = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        pixel_req   = 1'b0;
        vectors++;
        if (pixel_valid !== 1'b0) begin miscompares++; $display("FAIL restart_req_collision_valid got %0b want 0", pixel_valid); end
        wait_cmds(5, 40, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL restart_cmd5_timeout commands got %0d want 5", cmd_addr_q.size());
            return;
        end
        vectors += 4;
        if (cmd_addr_q[4] !== 30'd0) begin miscompares++; $display("FAIL restart_cmd5_addr got %0d want 0", cmd_addr_q[4]); end
        if (cmd_bl_q[4] !== 6'd15) begin miscompares++; $display("FAIL restart_cmd5_bl got %0d want 15", cmd_bl_q[4]); end
        if (q_at_cmd[4] !== 0) begin miscompares++; $display("FAIL restart_mcb_leftover got %0d want 0", q_at_cmd[4]); end
        if (pops_at_cmd[4] - base !== 16) begin miscompares++; $display("FAIL restart_old_burst_pops got %0d want 16", pops_at_cmd[4] - base); end
        repeat (20) @(negedge clk);
        pixel_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 7) pixel_req = 1'b0;
            vectors += 2;
            if (pixel_valid !== 1'b1) begin miscompares++; $display("FAIL restart_valid[%0d] got %0b want 1", i, pixel_valid); end
            if (pixel_data !== 32'(i)) begin miscompares++; $display("FAIL restart_data[%0d] got %0d want %0d", i, pixel_data, i); end
        end
        vectors++;
        if (underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_sticky got %0b want 1", underflow); end
    endtask

    initial begin
        test_reset();
        test_calib_gating();
        test_backpressure();
        test_pixel_stream();
        test_back_to_back();
        test_underflow();
        test_frame_restart();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
